// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between master 0 (CPU load/store path)
// and master 1 (UART loader / debug port).
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   mX_req/we/addr/wdata  request from master X (fields stable until granted)
//   mX_gnt                combinational grant, the access happens this cycle
//   mX_rvalid/rdata       registered read return, one cycle after a read grant
//   ram_we/addr/wdata     RAM drive (combinational from the grant mux)
//   ram_rdata             RAM read data; the RAM runs on the inverted clock, so data for
//                         the address driven in cycle N is stable before its closing edge
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned M0_BURST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned BurstW = $clog2(M0_BURST_MAX + 1);

    typedef enum logic {PrioM0, PrioM1} prio_e;

    prio_e              ptr_q, ptr_d;
    logic [BurstW-1:0]  burst_q, burst_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               gnt0, gnt1;

    // Byte-lane and upper address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                                m1_addr[31:ADDR_W+2], m1_addr[1:0]};

    // Arbitration from registered pointer/burst state; nothing is granted during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                if (burst_q >= BurstW'(M0_BURST_MAX)) begin
                    gnt1 = 1'b1;
                end else if (ptr_q == PrioM1) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // RAM drive; address and write data hold their last value when idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (gnt0) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr[ADDR_W+1:2];
            ram_wdata = m0_wdata;
        end else if (gnt1) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr[ADDR_W+1:2];
            ram_wdata = m1_wdata;
        end
    end

    always_comb begin
        addr_d  = ram_addr;
        wdata_d = ram_wdata;

        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = PrioM1;
        end else if (gnt1) begin
            ptr_d = PrioM0;
        end

        burst_d = burst_q;
        if (gnt1 || !m1_req) begin
            burst_d = '0;
        end else if (gnt0 && (burst_q < BurstW'(M0_BURST_MAX))) begin
            burst_d = burst_q + 1'b1;
        end

        rvalid0_d = gnt0 & ~m0_we;
        rvalid1_d = gnt1 & ~m1_we;
        rdata0_d  = rvalid0_d ? ram_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q     <= PrioM0;
            burst_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: master 0 (CPU load/store path) and master 1 (UART program/data loader or debug port).
- Per cycle: grants at most one master, drives the RAM write-enable/word-address/write-data, and returns registered read data with a valid strobe.
- Sits between the requesters and the data-memory wrapper. The RAM is clocked on the inverted clock, so read data for an address driven in cycle N is stable before the rising edge that ends cycle N.

Parameters:
- ADDR_W, 14, RAM word-address width; word address = byte address [ADDR_W+1:2].
- DATA_W, 32, data width.
- M0_BURST_MAX, 4, maximum consecutive grants to master 0 while master 1 is waiting.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 access request; held with its fields stable until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address; bits [1:0] and above ADDR_W+1 ignored.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  combinational grant; the access is performed this cycle.
- m0_rvalid  out  1  registered; read data valid (one-cycle pulse).
- m0_rdata  out  DATA_W  registered read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- ram_we  out  1  RAM write enable (wea).
- ram_addr  out  ADDR_W  RAM word address (addra).
- ram_wdata  out  DATA_W  RAM write data (dina).
- ram_rdata  in  DATA_W  RAM read data (douta).

Behaviour:
- Reset (async, immediate): m0_gnt = m1_gnt = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, both rvalid = 0, both rdata = 0, priority pointer = master 0, burst counter = 0. While reset is high, no grant is issued and any pending read return is discarded.
- Arbitration is combinational in the current cycle, using registered state:
  - Only one master requesting: that master is granted.
  - Both requesting: the master selected by the priority pointer is granted, with one override: if master 0 has had M0_BURST_MAX consecutive grants, master 1 is granted.
  - Neither requesting: no grant, ram_we = 0, ram_addr/ram_wdata hold their last value.
- Pointer update on each grant: the pointer moves to the non-granted master (round-robin). Maximum wait for any requester is therefore 1 cycle.
- Burst counter:
  - Increments on each m0 grant while m1_req = 1, saturating at M0_BURST_MAX.
  - Clears on an m1 grant, or on any cycle where m1_req = 0.
- RAM drive in a grant cycle: ram_addr = granted addr[ADDR_W+1:2], ram_wdata = granted wdata, ram_we = granted we. All are combinational from the grant mux.
- Read return:
  - A granted read in cycle N captures ram_rdata at the rising edge ending cycle N.
  - In cycle N+1, mX_rvalid = 1 and mX_rdata holds the captured data. Latency is 1 cycle after grant.
  - rdata holds until the next read return to that master. rvalid is a single-cycle pulse.
- Writes produce no rvalid. A write is complete at the end of its grant cycle.
- Back-to-back accesses: one master may be granted every cycle, and a read return and a new grant may coincide. A write followed by a read to the same word in the next cycle returns the new data.
- Dropping a request: deasserting req before grant cancels it with no side effects. Request fields may change only after gnt.
- Reset asserted mid-access: ram_we drops at once and the pending rvalid is not issued after reset is released.
- The RAM is never driven with ram_we = 1 outside a grant cycle.

Test Plan:
- Reset, then m0 write 0x12345678 to byte address 0x10 -> m0_gnt = 1 that cycle, ram_we = 1, ram_addr = 0x4. Then m0 read 0x10 -> m0_rvalid = 1 one cycle after grant, m0_rdata = 0x12345678.
- m0 and m1 request reads every cycle after reset -> grants alternate m0, m1, m0, ...; each master's rvalid follows its own grant by 1 cycle, and rdata matches preloaded RAM contents.
- m1 alone writes 0xDEADBEEF to 0x20 while m0 is idle -> m1_gnt every request cycle, m0_gnt = 0, no m0_rvalid.
- Same-cycle collision: m0 write 0xA5A5A5A5 to 0x8 and m1 read 0x8, with the pointer at m0 -> m0 granted first; m1 is granted the next cycle and reads 0xA5A5A5A5.
- Assert reset in the cycle after an m1 read grant -> m1_rvalid stays 0, ram_we = 0 immediately. After release, the first simultaneous request goes to m0.
- Address aliasing: m0 read of 0x10 and of 0x13 -> same ram_addr 0x4 and identical data. An address with bit 16 set (ADDR_W = 14) maps to the same word as with that bit cleared.
